e_scale_ctrl: RTL and testbench

Sequencer for the E_Scale quantization stage. It holds a per-channel-pair table of E_scale tail/rank sets and streams one set per group of rows. Each set is presented one cycle ahead of its first row, so the set lines up with E_Scale's internal tail register (1 stage) and rank register (2 stages). It gates row acceptance with a valid/ready handshake and generates the output-valid, set-index and last-row markers that accompany quantified_row.

---
 rtl/e_scale_ctrl_pkg.sv | 26 ++
 rtl/e_scale_set_table.sv | 19 +
 rtl/e_scale_ctrl.sv | 107 ++++++++++
 tb/tb_e_scale_ctrl.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/e_scale_ctrl_pkg.sv
// Shared constants, FSM encoding and table entry type for the E_Scale sequencer.
package e_scale_ctrl_pkg;
  localparam int set_num_max            = 64;
  localparam int set_idx_width          = 6;
  localparam int E_scale_tail_set_width = 32;
  localparam int E_scale_rank_set_width = 16;
  localparam int row_cnt_width          = 8;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_PRIME  = 3'd1;
  localparam logic [2:0] ST_RUN    = 3'd2;
  localparam logic [2:0] ST_SWITCH = 3'd3;
  localparam logic [2:0] ST_DRAIN  = 3'd4;

  typedef struct packed {
    logic [E_scale_tail_set_width-1:0] tail;
    logic [E_scale_rank_set_width-1:0] rank;
  } set_entry_t;

  // Zero means one set; anything past the table depth is clamped to it.
  function automatic logic [set_idx_width:0] clamp_set_num(input logic [set_idx_width:0] n);
    if (n == '0) return (set_idx_width+1)'(1);
    if (n > (set_idx_width+1)'(set_num_max)) return (set_idx_width+1)'(set_num_max);
    return n;
  endfunction
endpackage

// File: rtl/e_scale_set_table.sv
// Tail/rank set register file: one synchronous write port, one asynchronous read port.
module e_scale_set_table
  import e_scale_ctrl_pkg::*;
(
  input  logic                     clk,
  input  logic                     wr_en,
  input  logic [set_idx_width-1:0] wr_addr,
  input  set_entry_t               wr_data,
  input  logic [set_idx_width-1:0] rd_addr,
  output set_entry_t               rd_data
);
  // Contents deliberately survive reset.
  set_entry_t mem [set_num_max];

  always_ff @(posedge clk)
    if (wr_en) mem[wr_addr] <= wr_data;

  assign rd_data = mem[rd_addr];
endmodule

// File: rtl/e_scale_ctrl.sv
// E_Scale sequencer: streams one tail/rank set per row group, one cycle ahead of its first row.
module e_scale_ctrl
  import e_scale_ctrl_pkg::*;
(
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              cfg_start,
  input  logic                              cfg_mode,
  input  logic [set_idx_width:0]            cfg_set_num,
  input  logic [row_cnt_width-1:0]          cfg_rows_per_set,
  input  logic                              tbl_wr_en,
  input  logic [set_idx_width-1:0]          tbl_wr_addr,
  input  logic [E_scale_tail_set_width-1:0] tbl_wr_tail,
  input  logic [E_scale_rank_set_width-1:0] tbl_wr_rank,
  input  logic                              row_in_valid,
  output logic                              row_in_ready,
  output logic                              mode,
  output logic                              e_tail_reset,
  output logic [E_scale_tail_set_width-1:0] E_scale_tail_set,
  output logic [E_scale_rank_set_width-1:0] E_scale_rank_set,
  output logic                              q_valid,
  output logic [set_idx_width-1:0]          q_set_idx,
  output logic                              q_last,
  output logic                              busy,
  output logic                              done
);
  logic [2:0]               state;
  logic [set_idx_width-1:0] set_idx;
  logic [row_cnt_width-1:0] row_cnt, rows_q;
  logic [set_idx_width:0]   set_num_q;
  logic                     mode_q;
  logic                     accept, row_last, set_last;
  set_entry_t               rd_entry, wr_entry;

  assign wr_entry = '{tail: tbl_wr_tail, rank: tbl_wr_rank};

  e_scale_set_table u_tbl (
    .clk     (clk),
    .wr_en   (tbl_wr_en && (state == ST_IDLE)),
    .wr_addr (tbl_wr_addr),
    .wr_data (wr_entry),
    .rd_addr (set_idx),
    .rd_data (rd_entry)
  );

  assign row_in_ready = (state == ST_RUN);
  assign e_tail_reset = (state == ST_IDLE);
  assign busy         = (state != ST_IDLE);
  assign mode         = mode_q;
  assign accept       = row_in_valid && row_in_ready;
  assign row_last     = (row_cnt == rows_q - row_cnt_width'(1));
  assign set_last     = ({1'b0, set_idx} == set_num_q - (set_idx_width+1)'(1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= ST_IDLE;
      set_idx          <= '0;
      row_cnt          <= '0;
      rows_q           <= '0;
      set_num_q        <= '0;
      mode_q           <= 1'b0;
      E_scale_tail_set <= '0;
      E_scale_rank_set <= '0;
      q_valid          <= 1'b0;
      q_set_idx        <= '0;
      q_last           <= 1'b0;
      done             <= 1'b0;
    end else begin
      // Output markers travel one cycle behind the accept that produced them.
      q_valid   <= accept;
      q_set_idx <= set_idx;
      q_last    <= accept && row_last && set_last;
      done      <= 1'b0;
      case (state)
        ST_IDLE: if (cfg_start) begin
          mode_q    <= cfg_mode;
          set_num_q <= clamp_set_num(cfg_set_num);
          rows_q    <= (cfg_rows_per_set == '0) ? row_cnt_width'(1) : cfg_rows_per_set;
          set_idx   <= '0;
          row_cnt   <= '0;
          state     <= ST_PRIME;
        end
        ST_PRIME, ST_SWITCH: begin
          E_scale_tail_set <= rd_entry.tail;
          E_scale_rank_set <= rd_entry.rank;
          state            <= ST_RUN;
        end
        ST_RUN: if (accept) begin
          row_cnt <= row_cnt + row_cnt_width'(1);
          if (row_last) begin
            if (set_last) state <= ST_DRAIN;
            else begin
              set_idx <= set_idx + set_idx_width'(1);
              row_cnt <= '0;
              state   <= ST_SWITCH;
            end
          end
        end
        ST_DRAIN: if (q_valid && q_last) begin
          done  <= 1'b1;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_e_scale_ctrl.sv
// Scoreboard bench for e_scale_ctrl: table model, per-accept expectations, latency and bubble checks.
module tb_e_scale_ctrl;
  logic        clk = 1'b0;
  logic        reset;
  logic        cfg_start, cfg_mode;
  logic [6:0]  cfg_set_num;
  logic [7:0]  cfg_rows_per_set;
  logic        tbl_wr_en;
  logic [5:0]  tbl_wr_addr;
  logic [31:0] tbl_wr_tail;
  logic [15:0] tbl_wr_rank;
  logic        row_in_valid, row_in_ready, mode, e_tail_reset;
  logic [31:0] E_scale_tail_set;
  logic [15:0] E_scale_rank_set;
  logic        q_valid, q_last, busy, done;
  logic [5:0]  q_set_idx;

  typedef struct packed { logic [5:0] idx; logic last; } exp_t;
  exp_t sb[$];

  logic [31:0] m_tail [64];
  logic [15:0] m_rank [64];
  logic [15:0] r1, r2;
  int checks = 0, errors = 0;

  always #5 clk = ~clk;
  // Stand-in for E_Scale's two-stage rank register.
  always @(posedge clk) begin r1 <= E_scale_rank_set; r2 <= r1; end

  e_scale_ctrl dut (
    .clk(clk), .reset(reset), .cfg_start(cfg_start), .cfg_mode(cfg_mode),
    .cfg_set_num(cfg_set_num), .cfg_rows_per_set(cfg_rows_per_set),
    .tbl_wr_en(tbl_wr_en), .tbl_wr_addr(tbl_wr_addr), .tbl_wr_tail(tbl_wr_tail),
    .tbl_wr_rank(tbl_wr_rank), .row_in_valid(row_in_valid), .row_in_ready(row_in_ready),
    .mode(mode), .e_tail_reset(e_tail_reset), .E_scale_tail_set(E_scale_tail_set),
    .E_scale_rank_set(E_scale_rank_set), .q_valid(q_valid), .q_set_idx(q_set_idx),
    .q_last(q_last), .busy(busy), .done(done)
  );

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tbl_write(input int a, input logic [31:0] t, input logic [15:0] r);
    tbl_wr_en = 1'b1; tbl_wr_addr = 6'(a); tbl_wr_tail = t; tbl_wr_rank = r;
    m_tail[a] = t; m_rank[a] = r;
    @(negedge clk);
    tbl_wr_en = 1'b0;
  endtask

  // vpat 0: valid held high; 1: valid toggles. poke: write/start while busy. rst_at: reset after that many accepts.
  task automatic run_tile(input bit md, input int sn, input int rps, input int vpat,
                          input bit poke, input int rst_at);
    int sne, rpse, total, acc, cyc, last_acc, bubbles;
    bit got_done, aborted, mode_ok, v;
    exp_t e;
    sne  = (sn == 0) ? 1 : (sn > 64) ? 64 : sn;
    rpse = (rps == 0) ? 1 : rps;
    total = sne * rpse;
    acc = 0; cyc = 0; last_acc = 0; bubbles = 0;
    got_done = 0; aborted = 0; mode_ok = 1;
    chk("idle_busy", busy, 0);
    cfg_mode = md; cfg_set_num = 7'(sn); cfg_rows_per_set = 8'(rps); cfg_start = 1'b1;
    @(negedge clk);
    cfg_start = 1'b0;
    chk("prime_etr", e_tail_reset, 0);
    chk("prime_rdy", row_in_ready, 0);
    while (!got_done && !aborted && cyc < 2000) begin
      if (q_valid) begin
        if (sb.size() == 0) chk("q_unexpected", 1, 0);
        else begin
          e = sb.pop_front();
          chk("q_set_idx", q_set_idx, e.idx);
          chk("q_last", q_last, e.last);
        end
      end else if (sb.size() != 0) chk("q_missing", 0, 1);
      if (done) begin
        chk("done_latency", cyc - last_acc, 2);
        chk("done_rows", acc, total);
        got_done = 1;
      end
      if (busy && mode !== md) mode_ok = 0;
      if (cyc == 3) chk("rank_lo_e2", r2[7:0], m_rank[0][7:0]);
      if (!got_done) begin
        if (rst_at != 0 && acc == rst_at) begin
          reset = 1'b1; row_in_valid = 1'b0; aborted = 1;
        end else begin
          v = (vpat == 0) ? 1'b1 : (cyc % 2 == 0);
          row_in_valid = v;
          if (row_in_ready) begin
            chk("tail_set", E_scale_tail_set, m_tail[acc / rpse]);
            chk("rank_set", E_scale_rank_set, m_rank[acc / rpse]);
            if (v) begin
              e.idx = 6'(acc / rpse); e.last = (acc == total - 1);
              sb.push_back(e);
              acc++; last_acc = cyc;
            end
          end else if (acc > 0 && acc < total) bubbles++;
          if (poke && acc == 2) begin
            tbl_wr_en = 1'b1; tbl_wr_addr = 6'd0; tbl_wr_tail = 32'hDEAD_BEEF; tbl_wr_rank = 16'hFFFF;
            cfg_start = 1'b1; cfg_set_num = 7'd1; cfg_rows_per_set = 8'd1; cfg_mode = ~md;
          end else begin
            tbl_wr_en = 1'b0; cfg_start = 1'b0;
          end
        end
      end
      @(negedge clk);
      cyc++;
    end
    row_in_valid = 1'b0; tbl_wr_en = 1'b0; cfg_start = 1'b0;
    if (aborted) begin
      chk("rst_busy", busy, 0);
      chk("rst_etr", e_tail_reset, 1);
      chk("rst_qvalid", q_valid, 0);
      chk("rst_done", done, 0);
      sb.delete();
      reset = 1'b0;
      @(negedge clk);
      chk("rst_no_done", done, 0);
    end else begin
      chk("tile_timeout", got_done, 1);
      chk("mode_held", mode_ok, 1);
      if (vpat == 0) chk("bubbles", bubbles, sne - 1);
      chk("done_pulse", done, 0);
      chk("post_etr", e_tail_reset, 1);
    end
  endtask

  initial begin
    reset = 1'b1; cfg_start = 0; cfg_mode = 0; cfg_set_num = 0; cfg_rows_per_set = 0;
    tbl_wr_en = 0; tbl_wr_addr = 0; tbl_wr_tail = 0; tbl_wr_rank = 0; row_in_valid = 0;
    repeat (2) @(negedge clk);
    chk("rst_busy0", busy, 0);
    chk("rst_etr0", e_tail_reset, 1);
    chk("rst_rdy0", row_in_ready, 0);
    chk("rst_q0", {q_valid, q_last, done, mode}, 0);
    chk("rst_sets0", {E_scale_tail_set, E_scale_rank_set}, 0);
    reset = 1'b0;
    @(negedge clk);
    tbl_write(0, 32'h0010_0020, 16'h0304);
    tbl_write(1, 32'h0030_0040, 16'h0506);
    tbl_write(2, 32'h0050_0060, 16'h0708);
    run_tile(1, 2, 3, 0, 0, 0);
    run_tile(1, 2, 3, 1, 0, 0);
    run_tile(1, 2, 3, 0, 1, 0);
    run_tile(1, 2, 3, 0, 0, 2);
    run_tile(1, 2, 3, 0, 0, 0);
    run_tile(1, 1, 1, 0, 0, 0);
    run_tile(0, 3, 4, 0, 0, 0);
    run_tile(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 64; i++) tbl_write(i, $urandom, 16'($urandom));
    run_tile(1, 100, 1, 1, 0, 0);
    run_tile(0, 64, 2, 0, 0, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
